// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_ctrl                                                             |
// | MEM-stage controller: data-memory bus access, branch resolution, stall     |
// | and the MEM/WB write-back register.                                        |
// | Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned-access trap).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_stage_ctrl #(
  parameter int XLEN = 64,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            RegWrite_store,
  input  logic            MemtoReg_store,
  input  logic            Branch_store,
  input  logic            Zero_store,
  input  logic            Is_Greater_store,
  input  logic            MemWrite_store,
  input  logic            MemRead_store,
  input  logic [XLEN-1:0] PCplusimm_store,
  input  logic [XLEN-1:0] ALU_result_store,
  input  logic [XLEN-1:0] WriteData_store,
  input  logic [3:0]      funct_in_store,
  input  logic [4:0]      rd_store,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall,
  output logic            PCSrc,
  output logic [XLEN-1:0] branch_target,
  output logic            flush_req,
  output logic            misalign,
  output logic            RegWrite_wb,
  output logic            MemtoReg_wb,
  output logic [4:0]      rd_wb,
  output logic [XLEN-1:0] ReadData_wb,
  output logic [XLEN-1:0] ALU_result_wb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state;
  logic [1:0]      next_state;
  logic            mem_op;
  logic            trap;
  logic            go;
  logic            capture;
  logic            branch_cond;
  logic [2:0]      lane;
  logic [2:0]      funct3;
  logic [5:0]      lane_shift;
  logic [BE_W-1:0] size_mask;
  logic [XLEN-1:0] shifted_rdata;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] load_data_q;
  logic            unused_funct7;

  assign mem_op        = MemRead_store | MemWrite_store;
  assign lane          = ALU_result_store[2:0];
  assign funct3        = funct_in_store[2:0];
  assign lane_shift    = {lane, 3'b000};
  assign unused_funct7 = funct_in_store[3];

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = |lane[1:0];
      2'b11:   misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
  end

  assign trap = mem_op & misaligned;
`else
  assign trap = 1'b0;
`endif

  assign go = mem_op & ~trap;

  always_comb begin
    size_mask = '0;
    case (funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (go) next_state = S_REQ;
      S_REQ: begin
        if (mem_ready) begin
          if (MemWrite_store || mem_rvalid) next_state = S_DONE;
          else                              next_state = S_WAIT;
        end
      end
      S_WAIT: if (mem_rvalid) next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM: outputs; bus fields are driven only while the request is live
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    stall     = 1'b0;
    misalign  = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        stall    = go;
        misalign = trap;
      end
      S_REQ: begin
        mem_req   = 1'b1;
        mem_we    = MemWrite_store;
        mem_addr  = {ALU_result_store[XLEN-1:3], 3'b000};
        mem_wdata = WriteData_store << lane_shift;
        mem_be    = size_mask << lane;
        stall     = 1'b1;
        capture   = mem_ready & mem_rvalid & ~MemWrite_store;
      end
      S_WAIT: begin
        stall   = 1'b1;
        capture = mem_rvalid;
      end
      default: ;
    endcase
  end

  assign shifted_rdata = mem_rdata >> lane_shift;

  always_comb begin
    load_data = shifted_rdata;
    case (funct3)
      3'b000:  load_data = {{(XLEN-8){shifted_rdata[7]}},   shifted_rdata[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted_rdata[15]}}, shifted_rdata[15:0]};
      3'b010:  load_data = {{(XLEN-32){shifted_rdata[31]}}, shifted_rdata[31:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}},  shifted_rdata[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted_rdata[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}}, shifted_rdata[31:0]};
      default: load_data = shifted_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     load_data_q <= '0;
    else if (capture) load_data_q <= load_data;
  end

  // A stalled or trapped instruction must not retire, so a bubble goes to WB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite_wb   <= 1'b0;
      MemtoReg_wb   <= 1'b0;
      rd_wb         <= '0;
      ReadData_wb   <= '0;
      ALU_result_wb <= '0;
    end else if (stall || misalign) begin
      RegWrite_wb   <= 1'b0;
      MemtoReg_wb   <= 1'b0;
      rd_wb         <= '0;
      ReadData_wb   <= '0;
      ALU_result_wb <= '0;
    end else begin
      RegWrite_wb   <= RegWrite_store;
      MemtoReg_wb   <= MemtoReg_store;
      rd_wb         <= rd_store;
      ReadData_wb   <= MemRead_store ? load_data_q : '0;
      ALU_result_wb <= ALU_result_store;
    end
  end

  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      3'b000:  branch_cond = Zero_store;
      3'b001:  branch_cond = ~Zero_store;
      3'b100:  branch_cond = ~Is_Greater_store & ~Zero_store;
      3'b101:  branch_cond = Is_Greater_store | Zero_store;
      default: branch_cond = 1'b0;
    endcase
  end

  assign PCSrc         = Branch_store & branch_cond;
  assign flush_req     = PCSrc;
  assign branch_target = PCplusimm_store;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage_ctrl                                                          |
// | Randomized self-checking bench for mem_stage_ctrl with a transaction model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        RegWrite_store, MemtoReg_store, Branch_store, Zero_store;
  logic        Is_Greater_store, MemWrite_store, MemRead_store;
  logic [63:0] PCplusimm_store, ALU_result_store, WriteData_store;
  logic [3:0]  funct_in_store;
  logic [4:0]  rd_store;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic        stall, PCSrc, flush_req, misalign;
  logic [63:0] branch_target;
  logic        RegWrite_wb, MemtoReg_wb;
  logic [4:0]  rd_wb;
  logic [63:0] ReadData_wb, ALU_result_wb;

  mem_stage_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .RegWrite_store(RegWrite_store), .MemtoReg_store(MemtoReg_store),
    .Branch_store(Branch_store), .Zero_store(Zero_store),
    .Is_Greater_store(Is_Greater_store), .MemWrite_store(MemWrite_store),
    .MemRead_store(MemRead_store), .PCplusimm_store(PCplusimm_store),
    .ALU_result_store(ALU_result_store), .WriteData_store(WriteData_store),
    .funct_in_store(funct_in_store), .rd_store(rd_store),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall),
    .PCSrc(PCSrc), .branch_target(branch_target), .flush_req(flush_req),
    .misalign(misalign), .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
    .rd_wb(rd_wb), .ReadData_wb(ReadData_wb), .ALU_result_wb(ALU_result_wb)
  );

  typedef struct {
    logic        rw, m2r, br, z, g, mw, mr;
    logic [63:0] pci, alu, wd, rdata;
    logic [3:0]  funct;
    logic [4:0]  rd;
    int          dr, dv;   // cycles before mem_ready, cycles from ready to rvalid
  } instr_t;

  int   tests = 0;
  int   fails = 0;
  logic checking = 1'b0;

  logic        exp_stall, exp_req, exp_we, exp_store, exp_pcsrc, exp_mis;
  logic [63:0] exp_addr, exp_wdata, exp_target;
  logic [7:0]  exp_be;
  logic        exp_wb_valid, exp_rw, exp_m2r;
  logic [4:0]  exp_rd;
  logic [63:0] exp_alu_wb, exp_data_wb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_of(input instr_t t);
    return 1 << t.funct[1:0];
  endfunction

  function automatic logic trap_of(input instr_t t);
`ifdef MEM_MISALIGN_TRAP_EN
    return (t.mr || t.mw) && ((int'(t.alu[2:0]) % size_of(t)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] be_of(input instr_t t);
    int m;
    m = ((1 << size_of(t)) - 1) << int'(t.alu[2:0]);
    return 8'(m & 255);
  endfunction

  function automatic logic [63:0] load_of(input instr_t t);
    logic [63:0]        s;
    logic signed [63:0] r;
    s = t.rdata >> (8 * int'(t.alu[2:0]));
    case (t.funct[2:0])
      3'd0:    r = $signed(s[7:0]);
      3'd1:    r = $signed(s[15:0]);
      3'd2:    r = $signed(s[31:0]);
      3'd4:    r = s & 64'hFF;
      3'd5:    r = s & 64'hFFFF;
      3'd6:    r = s & 64'hFFFF_FFFF;
      default: r = s;
    endcase
    return r;
  endfunction

  // Relation-level view of the compare flags: equal / greater / less
  function automatic logic pcsrc_of(input instr_t t);
    logic eq, lt;
    eq = t.z;
    lt = !t.z && !t.g;
    if (!t.br) return 1'b0;
    case (t.funct[2:0])
      3'd0:    return eq;
      3'd1:    return !eq;
      3'd4:    return lt;
      3'd5:    return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic instr_t nop();
    instr_t t;
    t = '{rw: 0, m2r: 0, br: 0, z: 0, g: 0, mw: 0, mr: 0, pci: 0, alu: 0,
          wd: 0, rdata: 0, funct: 0, rd: 0, dr: 0, dv: 0};
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int     kind;
    t       = nop();
    kind    = int'($urandom % 4);
    t.rw    = 1'($urandom);
    t.m2r   = 1'($urandom);
    t.z     = 1'($urandom);
    t.g     = t.z ? 1'b0 : 1'($urandom);
    t.pci   = {$urandom, $urandom};
    t.alu   = {$urandom, $urandom};
    t.wd    = {$urandom, $urandom};
    t.rdata = {$urandom, $urandom};
    t.funct = 4'($urandom);
    t.rd    = 5'($urandom);
    t.dr    = int'($urandom % 4);
    t.dv    = int'($urandom % 4);
    case (kind)
      1: t.br = 1'b1;
      2: begin t.mr = 1'b1; t.funct[2:0] = 3'($urandom % 7); end
      3: begin t.mw = 1'b1; t.funct[2:0] = 3'($urandom % 4); end
      default: ;
    endcase
    return t;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      chk("stall", stall, exp_stall);
      chk("mem_req", mem_req, exp_req);
      chk("PCSrc", PCSrc, exp_pcsrc);
      chk("flush_req", flush_req, exp_pcsrc);
      chk("branch_target", branch_target, exp_target);
      chk("misalign", misalign, exp_mis);
      if (exp_req) begin
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", mem_be, exp_be);
        if (exp_store) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("RegWrite_wb", RegWrite_wb, exp_rw);
      chk("MemtoReg_wb", MemtoReg_wb, exp_m2r);
      chk("rd_wb", rd_wb, exp_rd);
      if (exp_wb_valid) begin
        chk("ALU_result_wb", ALU_result_wb, exp_alu_wb);
        chk("ReadData_wb", ReadData_wb, exp_data_wb);
      end
    end
  end

  task automatic apply(input instr_t t);
    RegWrite_store   = t.rw;   MemtoReg_store   = t.m2r;
    Branch_store     = t.br;   Zero_store       = t.z;
    Is_Greater_store = t.g;    MemWrite_store   = t.mw;
    MemRead_store    = t.mr;   PCplusimm_store  = t.pci;
    ALU_result_store = t.alu;  WriteData_store  = t.wd;
    funct_in_store   = t.funct; rd_store        = t.rd;
  endtask

  // Holds one instruction in EX/MEM until it leaves, acting as the memory too
  task automatic run(input instr_t t, output int stall_seen, output logic req_seen,
                     output logic [63:0] addr_seen, output logic [63:0] wdata_seen,
                     output logic [7:0] be_seen, output logic pc_seen, output logic mis_seen);
    int   n;
    logic acc;
    acc = (t.mr || t.mw) && !trap_of(t);
    n   = !acc ? 1 : (t.mw ? 3 + t.dr : 3 + t.dr + t.dv);
    apply(t);
    exp_target = t.pci;
    exp_pcsrc  = pcsrc_of(t);
    exp_mis    = trap_of(t);
    exp_we     = t.mw;
    exp_store  = t.mw;
    exp_addr   = {t.alu[63:3], 3'b000};
    exp_be     = be_of(t);
    exp_wdata  = t.wd << (8 * int'(t.alu[2:0]));
    stall_seen = 0; req_seen = 0; addr_seen = 0; wdata_seen = 0;
    be_seen = 0; pc_seen = 0; mis_seen = 0;
    for (int k = 0; k < n; k++) begin
      exp_req   = acc && k >= 1 && k <= 1 + t.dr;
      exp_stall = acc && k < n - 1;
      mem_ready = exp_req && k == 1 + t.dr;
      if (acc) begin
        mem_rvalid = t.mr && k == 1 + t.dr + t.dv;
        mem_rdata  = t.rdata;
      end else begin
        mem_rvalid = 1'($urandom);
        mem_rdata  = {$urandom, $urandom};
      end
      @(negedge clk);
      if (stall) stall_seen++;
      if (mem_req) begin
        req_seen = 1'b1; addr_seen = mem_addr; wdata_seen = mem_wdata; be_seen = mem_be;
      end
      if (k == 0) pc_seen = PCSrc;
      if (misalign) mis_seen = 1'b1;
      @(posedge clk);
      #1;
      if (exp_stall || exp_mis) begin
        exp_wb_valid = 0; exp_rw = 0; exp_m2r = 0; exp_rd = 0;
      end else begin
        exp_wb_valid = 1; exp_rw = t.rw; exp_m2r = t.m2r; exp_rd = t.rd;
        exp_alu_wb   = t.alu;
        exp_data_wb  = t.mr ? load_of(t) : 64'd0;
      end
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    instr_t      t;
    int          st;
    logic        rq, pc, mis;
    logic [63:0] ad, wd;
    logic [7:0]  be;

    reset_n = 1'b0;
    apply(nop());
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_store = 0; exp_pcsrc = 0; exp_mis = 0;
    exp_addr = 0; exp_wdata = 0; exp_target = 0; exp_be = 0;
    exp_wb_valid = 1; exp_rw = 0; exp_m2r = 0; exp_rd = 0; exp_alu_wb = 0; exp_data_wb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_RegWrite_wb", RegWrite_wb, 0);
    chk("rst_rd_wb", rd_wb, 0);
    chk("rst_ReadData_wb", ReadData_wb, 0);
    chk("rst_ALU_result_wb", ALU_result_wb, 0);
    reset_n  = 1'b1;
    checking = 1'b1;

    // add, ALU_result=0x55, rd=7
    t = nop(); t.rw = 1; t.alu = 64'h55; t.rd = 5'd7;
    run(t, st, rq, ad, wd, be, pc, mis);
    chk("add_stall_cycles", 64'(st), 0);
    chk("add_ALU_result_wb", ALU_result_wb, 64'h55);
    chk("add_rd_wb", rd_wb, 7);
    chk("add_RegWrite_wb", RegWrite_wb, 1);

    // lb at 0x1003, ready and rvalid one cycle apart
    t = nop(); t.mr = 1; t.rw = 1; t.m2r = 1; t.rd = 5'd3; t.alu = 64'h1003;
    t.funct = 4'b0000; t.rdata = 64'h0000_0000_8000_0000; t.dr = 0; t.dv = 1;
    run(t, st, rq, ad, wd, be, pc, mis);
    chk("lb_addr", ad, 64'h1000);
    chk("lb_be", be, 8'h08);
    chk("lb_stall_cycles", 64'(st), 3);
    chk("lb_ReadData_wb", ReadData_wb, 64'hFFFF_FFFF_FFFF_FF80);

    // sd at 0x2000 with mem_ready held low 4 cycles
    t = nop(); t.mw = 1; t.alu = 64'h2000; t.wd = 64'h1122_3344_5566_7788;
    t.funct = 4'b0011; t.dr = 4;
    run(t, st, rq, ad, wd, be, pc, mis);
    chk("sd_addr", ad, 64'h2000);
    chk("sd_be", be, 8'hFF);
    chk("sd_wdata", wd, 64'h1122_3344_5566_7788);
    chk("sd_stall_cycles", 64'(st), 6);

    // bne taken, then bge not taken
    t = nop(); t.br = 1; t.funct = 4'b0001; t.pci = 64'h400;
    run(t, st, rq, ad, wd, be, pc, mis);
    chk("bne_PCSrc", pc, 1);
    chk("bne_flush_req", flush_req, 1);
    chk("bne_branch_target", branch_target, 64'h400);
    chk("bne_stall_cycles", 64'(st), 0);
    t = nop(); t.br = 1; t.funct = 4'b0101;
    run(t, st, rq, ad, wd, be, pc, mis);
    chk("bge_PCSrc", pc, 0);

    // lhu at 0x3001
    t = nop(); t.mr = 1; t.rw = 1; t.rd = 5'd9; t.alu = 64'h3001; t.funct = 4'b0101;
    t.rdata = 64'h0000_0000_00AB_CD00;
    run(t, st, rq, ad, wd, be, pc, mis);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("lhu_trap_req", rq, 0);
    chk("lhu_trap_misalign", mis, 1);
    chk("lhu_trap_stall_cycles", 64'(st), 0);
    chk("lhu_trap_RegWrite_wb", RegWrite_wb, 0);
`else
    chk("lhu_be", be, 8'h06);
    chk("lhu_misalign", mis, 0);
    chk("lhu_ReadData_wb", ReadData_wb, 64'h0000_0000_0000_ABCD);
`endif

    // reset while waiting for read data
    checking = 1'b0;
    t = nop(); t.mr = 1; t.rw = 1; t.rd = 5'd4; t.alu = 64'h100; t.funct = 4'b0011;
    apply(t);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("wait_stall", stall, 1);
    apply(nop());
    reset_n = 1'b0;
    #1;
    chk("rstwait_mem_req", mem_req, 0);
    chk("rstwait_stall", stall, 0);
    chk("rstwait_RegWrite_wb", RegWrite_wb, 0);
    chk("rstwait_ReadData_wb", ReadData_wb, 0);
    @(posedge clk); #1;
    reset_n    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    chk("late_rvalid_stall", stall, 0);
    chk("late_rvalid_mem_req", mem_req, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("late_rvalid_ReadData_wb", ReadData_wb, 0);
    chk("late_rvalid_RegWrite_wb", RegWrite_wb, 0);
    exp_stall = 0; exp_req = 0; exp_pcsrc = 0; exp_mis = 0; exp_target = 0;
    exp_wb_valid = 1; exp_rw = 0; exp_m2r = 0; exp_rd = 0; exp_alu_wb = 0; exp_data_wb = 0;
    checking = 1'b1;

    for (int i = 0; i < 300; i++) begin
      t = rand_instr();
      run(t, st, rq, ad, wd, be, pc, mis);
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
